// File: rtl/irq_priority_encoder.sv
//==============================================================================
// Module   : irq_priority_encoder
// Function : 8-line edge-latched interrupt controller with nesting and EOI.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module irq_priority_encoder #(
  parameter int                 VEC_W    = 3,
  parameter logic [VEC_W-1:0]   SPUR_VEC = 3'b111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2**VEC_W-1:0]   irq_in,
  input  logic                  mask_we,
  input  logic [2**VEC_W-1:0]   mask_wdata,
  output logic [2**VEC_W-1:0]   mask_q,
  output logic                  int_req,
  input  logic                  int_ack,
  output logic [VEC_W-1:0]      vec_out,
  output logic                  vec_valid,
  input  logic                  eoi,
  output logic [2**VEC_W-1:0]   pending_q,
  output logic [2**VEC_W-1:0]   in_service_q
);

  localparam int N = 2**VEC_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [N-1:0]       r_sync1, r_sync2, r_prev;
  logic [N-1:0]       r_mask, r_pend, r_isr;
  logic [VEC_W-1:0]   r_vec;

  logic [N-1:0]       w_rise, w_elig, w_grant_mask, w_isr_eoi;
  logic [VEC_W-1:0]   w_cand;
  logic               w_cand_hit;
  logic [VEC_W:0]     w_thr;
  logic               w_have_cand;
  logic               w_ack_take;
  logic               w_grant;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_elig = r_pend & ~r_mask;

  // Scan from lowest priority upward so the last hit is the highest priority.
  always_comb begin
    w_cand     = '0;
    w_cand_hit = 1'b0;
    w_thr      = (VEC_W+1)'(N);
    for (int i = N-1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_cand     = VEC_W'(i);
        w_cand_hit = 1'b1;
      end
      if (r_isr[i]) begin
        w_thr = (VEC_W+1)'(i);
      end
    end
  end

  // Nesting: only a strictly higher-priority request than anything in service.
  assign w_have_cand = w_cand_hit && ({1'b0, w_cand} < w_thr);

  always_comb begin
    w_state_nxt = r_state;
    w_ack_take  = 1'b0;
    case (r_state)
      S_IDLE: if (w_have_cand) w_state_nxt = S_REQ;
      S_REQ: begin
        if (int_ack) begin
          w_state_nxt = S_ACK;
          w_ack_take  = 1'b1;
        end else if (!w_have_cand) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant      = w_ack_take && w_have_cand;
  assign w_grant_mask = w_grant ? (N'(1) << w_cand) : '0;
  // Clearing the lowest set bit; an empty ISR stays empty.
  assign w_isr_eoi    = eoi ? (r_isr & (r_isr - N'(1))) : r_isr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_mask  <= '1;
      r_pend  <= '0;
      r_isr   <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (mask_we) r_mask <= mask_wdata;
      // A fresh edge wins over the acknowledge clear of the same bit.
      r_pend  <= (r_pend & ~w_grant_mask) | w_rise;
      r_isr   <= w_isr_eoi | w_grant_mask;
      if (w_ack_take) r_vec <= w_have_cand ? w_cand : SPUR_VEC;
    end
  end

  assign int_req      = (r_state == S_REQ);
  assign vec_valid    = (r_state == S_ACK);
  assign vec_out      = r_vec;
  assign mask_q       = r_mask;
  assign pending_q    = r_pend;
  assign in_service_q = r_isr;

endmodule

`default_nettype wire

// File: tb/tb_irq_priority_encoder.sv
//==============================================================================
// Module   : tb_irq_priority_encoder
// Function : Self-checking bench: vector table, directed corners, random vs model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_irq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask_q;
  logic       int_req;
  logic       int_ack;
  logic [2:0] vec_out;
  logic       vec_valid;
  logic       eoi;
  logic [7:0] pending_q;
  logic [7:0] in_service_q;

  int tests = 0;
  int fails = 0;

  irq_priority_encoder #(.VEC_W(3), .SPUR_VEC(3'b111)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_q(mask_q),
    .int_req(int_req), .int_ack(int_ack), .vec_out(vec_out),
    .vec_valid(vec_valid), .eoi(eoi), .pending_q(pending_q),
    .in_service_q(in_service_q)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: abstract phase + plain bit arrays, advanced once per edge.
  int         m_phase;   // 0 idle, 1 requesting, 2 acknowledged
  logic [7:0] m_s1, m_s2, m_prev, m_mask, m_pend, m_isr;
  logic [2:0] m_vec;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_s1 = 0; m_s2 = 0; m_prev = 0;
    m_mask = 8'hFF; m_pend = 0; m_isr = 0; m_vec = 0;
  endtask

  task automatic model_step();
    logic [7:0] rise;
    int c, t, np;
    bit hc, grant;
    rise  = m_s2 & ~m_prev;
    c     = lowest(m_pend & ~m_mask);
    t     = lowest(m_isr);
    hc    = (c < 8) && (c < t);
    grant = 0;
    np    = m_phase;
    if (m_phase == 0) begin
      if (hc) np = 1;
    end else if (m_phase == 1) begin
      if (int_ack) begin
        np = 2;
        if (hc) begin grant = 1; m_vec = 3'(c); end
        else m_vec = 3'd7;
      end else if (!hc) np = 0;
    end else np = 0;
    m_phase = np;
    if (eoi && t < 8) m_isr[t] = 1'b0;
    if (grant) begin m_isr[c] = 1'b1; m_pend[c] = 1'b0; end
    m_pend = m_pend | rise;
    if (mask_we) m_mask = mask_wdata;
    m_prev = m_s2; m_s2 = m_s1; m_s1 = irq_in;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!int_req && n < maxc) begin cycle(); n++; end
    check("wait_int_req", 32'(int_req), 32'd1);
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1; cycle(); int_ack = 1'b0;
  endtask

  task automatic eoi_pulse();
    eoi = 1'b1; cycle(); eoi = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic [7:0] irq; logic mwe; logic [7:0] mwd; logic ack; logic eo;
    logic ereq; logic evv; logic [2:0] evec; logic [7:0] epend; logic [7:0] eisr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] r;
    logic [7:0]  pend_at_rst;
    int          bad;

    tbl[0] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};
    tbl[1] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};
    tbl[2] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};
    tbl[3] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h20, 8'h00};
    tbl[4] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h20, 8'h00};
    tbl[5] = '{8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 8'h20};
    tbl[6] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 8'h20};
    tbl[7] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 8'h00};
    tbl[8] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 8'h00};

    rst_n = 1'b0; irq_in = 0; mask_we = 0; mask_wdata = 0; int_ack = 0; eoi = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_mask", 32'(mask_q), 32'hFF);
    check("rst_pend", 32'(pending_q), 32'h00);
    check("rst_isr", 32'(in_service_q), 32'h00);
    check("rst_req_vv_vec", {28'd0, int_req, vec_valid, 2'b00} | 32'(vec_out), 32'd0);

    // Basic latency and acknowledge on line 5
    for (int i = 0; i < 9; i++) begin
      irq_in = tbl[i].irq; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
      int_ack = tbl[i].ack; eoi = tbl[i].eo;
      cycle();
      check($sformatf("tbl%0d_req", i), 32'(int_req), 32'(tbl[i].ereq));
      check($sformatf("tbl%0d_vv", i), 32'(vec_valid), 32'(tbl[i].evv));
      check($sformatf("tbl%0d_vec", i), 32'(vec_out), 32'(tbl[i].evec));
      check($sformatf("tbl%0d_pend", i), 32'(pending_q), 32'(tbl[i].epend));
      check($sformatf("tbl%0d_isr", i), 32'(in_service_q), 32'(tbl[i].eisr));
    end
    mask_we = 0; int_ack = 0; eoi = 0;

    // Two simultaneous requests; lower-priority one blocked until EOI
    irq_in = 8'h44;
    wait_req(8);
    ack_pulse();
    check("s2_vv", 32'(vec_valid), 32'd1);
    check("s2_vec", 32'(vec_out), 32'd2);
    check("s2_isr", 32'(in_service_q), 32'h04);
    check("s2_pend", 32'(pending_q), 32'h40);
    ack_pulse();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (int_req || vec_valid) bad++;
    end
    check("s2_blocked", 32'(bad), 32'd0);
    eoi_pulse();
    wait_req(4);
    ack_pulse();
    check("s2_vec6", 32'(vec_out), 32'd6);
    check("s2_isr6", 32'(in_service_q), 32'h40);
    eoi_pulse();
    check("s2_isr_clr", 32'(in_service_q), 32'h00);
    irq_in = 0; idle(4);

    // Nesting: line 1 preempts line 4 in service
    irq_in = 8'h10;
    wait_req(8);
    ack_pulse();
    check("s3_isr10", 32'(in_service_q), 32'h10);
    irq_in = 8'h12;
    wait_req(8);
    ack_pulse();
    check("s3_vec1", 32'(vec_out), 32'd1);
    check("s3_isr12", 32'(in_service_q), 32'h12);
    eoi_pulse();
    check("s3_eoi", 32'(in_service_q), 32'h10);
    eoi_pulse();
    irq_in = 0; idle(4);

    // Masking while requesting withdraws int_req but keeps pending
    irq_in = 8'h08;
    wait_req(8);
    mask_we = 1; mask_wdata = 8'h08; cycle(); mask_we = 0;
    cycle();
    check("s4_req_drop", 32'(int_req), 32'd0);
    check("s4_pend", 32'(pending_q), 32'h08);
    mask_we = 1; mask_wdata = 8'h00; cycle(); mask_we = 0;
    wait_req(4);
    ack_pulse();
    check("s4_vec3", 32'(vec_out), 32'd3);
    eoi_pulse();
    irq_in = 0; idle(4);

    // Spurious acknowledge
    irq_in = 8'h10;
    wait_req(8);
    mask_we = 1; mask_wdata = 8'h10; cycle(); mask_we = 0;
    ack_pulse();
    check("s5_vv", 32'(vec_valid), 32'd1);
    check("s5_vec7", 32'(vec_out), 32'd7);
    check("s5_isr", 32'(in_service_q), 32'h00);
    check("s5_pend", 32'(pending_q), 32'h10);
    mask_we = 1; mask_wdata = 8'h00; cycle(); mask_we = 0;
    wait_req(4);
    ack_pulse();
    check("s5_vec4", 32'(vec_out), 32'd4);
    eoi_pulse();
    irq_in = 0; idle(4);

    // Asynchronous reset during a request
    irq_in = 8'h01;
    wait_req(8);
    pend_at_rst = pending_q;
    check("s6_pre_pend", 32'(pend_at_rst), 32'h01);
    #2 rst_n = 1'b0;
    irq_in = 0;
    #1;
    check("s6_req", 32'(int_req), 32'd0);
    check("s6_mask", 32'(mask_q), 32'hFF);
    check("s6_pend", 32'(pending_q), 32'h00);
    check("s6_vv_vec_isr", {vec_valid, 5'd0, vec_out, in_service_q}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ack_pulse();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (int_req || vec_valid) bad++;
      cycle();
    end
    check("s6_late_ack", 32'(bad), 32'd0);

    // Randomised traffic against the reference model
    for (int k = 0; k < 500; k++) begin
      r = $urandom & $urandom & $urandom;
      irq_in = irq_in ^ r[7:0];
      mask_we = ($urandom_range(0, 15) == 0);
      r = $urandom & $urandom;
      mask_wdata = r[7:0];
      int_ack = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 7) == 0);
      cycle();
      check($sformatf("rnd%0d", k),
            {int_req, vec_valid, vec_out, pending_q, in_service_q, mask_q},
            {(m_phase == 1), (m_phase == 2), m_vec, m_pend, m_isr, m_mask});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
